// File: rtl/if_prefetch_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_buf_pkg
//  Description : Shared constants, entry type and PC helper for the
//                instruction-fetch prefetch buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_prefetch_buf_pkg;

   localparam int          INST_W           = 32;
   localparam int          PC_W             = 32;
   localparam int          ENTRY_W          = INST_W + PC_W;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered fetch: the address it came from and the word read there.
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Instructions are word aligned; the low two address bits are dropped.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return {pc[PC_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_buf_sync_fifo
//  Description : Single-clock FIFO with registered storage, synchronous flush
//                and an explicit occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_buf_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_do_push;
   logic             w_do_pop;

   // Guard against overflow/underflow; flush overrides any transfer.
   always_comb begin
      w_do_push = i_push & ~i_flush & (r_count != CNT_W'(DEPTH));
      w_do_pop  = i_pop  & ~i_flush & (r_count != '0);
   end

   // Storage array: data only, no reset needed since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally; occupancy comes from the counter alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_prefetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_buf
//  Description : Instruction-fetch prefetch buffer. Owns the fetch PC, reads
//                the combinational instruction ROM and queues {pc, inst}
//                pairs for decode. A redirect flushes and restarts fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_buf
   import if_prefetch_buf_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   output logic                     rom_ce_o,
   output logic [31:0]              rom_addr_o,
   input  logic [31:0]              rom_data_i,
   output logic                     id_valid_o,
   input  logic                     id_ready_i,
   output logic [31:0]              id_inst_o,
   output logic [31:0]              id_pc_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]  r_fetch_pc;
   logic [CNT_W-1:0] w_count;
   logic             w_not_full;
   logic             w_nonempty;
   logic             w_push;
   logic             w_pop;
   fetch_entry_t     w_wr_entry;
   fetch_entry_t     w_rd_entry;
   logic [ENTRY_W-1:0] w_rd_raw;

   // Fetch enable and handshake qualification. Fetch never looks at
   // id_ready_i, so there is no ready-to-ROM combinational path; a pop in a
   // full cycle does not open a slot for a same-cycle push.
   always_comb begin
      w_not_full = (w_count < CNT_W'(DEPTH));
      w_nonempty = (w_count != '0);
      rom_ce_o   = ~rst & ~redirect_i & w_not_full;
      id_valid_o = w_nonempty & ~redirect_i;
      w_push     = rom_ce_o;
      w_pop      = id_valid_o & id_ready_i;
      w_wr_entry = '{pc: r_fetch_pc, inst: rom_data_i};
      w_rd_entry = fetch_entry_t'(w_rd_raw);
   end

   // Fetch PC: redirect has priority; otherwise advance by one word per push,
   // wrapping modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect_i) begin
         r_fetch_pc <= align_pc(redirect_pc_i);
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   if_prefetch_buf_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wr_entry),
      .o_rdata (w_rd_raw),
      .o_count (w_count)
   );

   // Head presentation: NOP / zero PC whenever the buffer holds nothing.
   always_comb begin
      rom_addr_o = r_fetch_pc;
      count_o    = w_count;
      id_inst_o  = w_nonempty ? w_rd_entry.inst : INST_NOP;
      id_pc_o    = w_nonempty ? w_rd_entry.pc   : 32'h0;
   end

endmodule
`default_nettype wire
